// File: rtl/dsp_acc_stream.sv
`default_nettype none
// ============================================================================
//  Module   : dsp_acc_stream
//  Purpose  : Frame accumulator behind the pre-add/multiply/compare DSP stage.
//             It sums up to N_ACC signed products per frame into an ACC_W-bit
//             accumulator. It counts the compare matches and the beats, and
//             keeps a sticky saturation/overflow flag. One result beat is
//             emitted per frame through a single-entry output register.
//  Option   : `define DSP_ACC_SAT_EN -> the accumulator add saturates, and
//             any clamp sets the sticky flag. When the macro is undefined the
//             add wraps modulo 2^ACC_W, and m_sat reflects only s_overflow.
//  Ports    : clk         clock, rising edge
//             rst         asynchronous reset, active low
//             s_tvalid    upstream product valid
//             s_tready    upstream beat accepted on s_tvalid && s_tready
//             s_tdata     signed product, 2*DW+1 bits
//             s_overflow  upstream overflow for this beat
//             s_sel       upstream compare-match flag for this beat
//             s_tlast     closes the frame on this beat
//             m_tvalid    result valid
//             m_tready    downstream accept
//             m_tdata     signed frame sum, ACC_W bits
//             m_match     number of beats with s_sel=1
//             m_count     number of beats in the frame (1..N_ACC)
//             m_sat       frame saturated or saw s_overflow
//  Revision : 1.0 - initial release
// ============================================================================
module dsp_acc_stream #(
    parameter  int DW    = 8,
    parameter  int N_ACC = 16,
    parameter  int ACC_W = 24,
    localparam int CW    = $clog2(N_ACC + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_tvalid,
    output logic                 s_tready,
    input  logic signed [2*DW:0] s_tdata,
    input  logic                 s_overflow,
    input  logic                 s_sel,
    input  logic                 s_tlast,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic signed [ACC_W-1:0] m_tdata,
    output logic [CW-1:0]        m_match,
    output logic [CW-1:0]        m_count,
    output logic                 m_sat
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic signed [ACC_W-1:0] r_acc;
    logic [CW-1:0]           r_cnt;
    logic [CW-1:0]           r_match;
    logic                    r_sat;

    logic                    r_m_tvalid;
    logic signed [ACC_W-1:0] r_m_tdata;
    logic [CW-1:0]           r_m_match;
    logic [CW-1:0]           r_m_count;
    logic                    r_m_sat;

    logic signed [ACC_W-1:0] w_acc_base;
    logic [CW-1:0]           w_cnt_base;
    logic [CW-1:0]           w_match_base;
    logic                    w_sat_base;
    logic signed [ACC_W-1:0] w_ext;
    logic signed [ACC_W-1:0] w_acc_nxt;
    logic [CW-1:0]           w_cnt_nxt;
    logic [CW-1:0]           w_match_nxt;
    logic                    w_sat_nxt;
    logic                    w_close;
    logic                    w_accept;

    // The frame state is taken from the IDLE constants whenever no frame is
    // open. This means a first beat never depends on stale register contents.
    assign w_acc_base   = (r_state == S_IDLE) ? '0   : r_acc;
    assign w_cnt_base   = (r_state == S_IDLE) ? '0   : r_cnt;
    assign w_match_base = (r_state == S_IDLE) ? '0   : r_match;
    assign w_sat_base   = (r_state == S_IDLE) ? 1'b0 : r_sat;

    assign w_ext       = ACC_W'(s_tdata);          // signed operand -> sign extension
    assign w_cnt_nxt   = w_cnt_base + CW'(1);
    assign w_match_nxt = w_match_base + CW'(s_sel);

`ifdef DSP_ACC_SAT_EN
    localparam logic signed [ACC_W-1:0] C_ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] C_ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W:0] w_sum_wide;
    logic                  w_pos_ovf;
    logic                  w_neg_ovf;

    // One guard bit. Overflow shows up as disagreement between the guard bit
    // and the result sign bit.
    assign w_sum_wide = $signed({w_acc_base[ACC_W-1], w_acc_base})
                      + $signed({w_ext[ACC_W-1], w_ext});
    assign w_pos_ovf  = ~w_sum_wide[ACC_W] &  w_sum_wide[ACC_W-1];
    assign w_neg_ovf  =  w_sum_wide[ACC_W] & ~w_sum_wide[ACC_W-1];
    assign w_acc_nxt  = w_pos_ovf ? C_ACC_MAX :
                        w_neg_ovf ? C_ACC_MIN : w_sum_wide[ACC_W-1:0];
    assign w_sat_nxt  = w_sat_base | s_overflow | w_pos_ovf | w_neg_ovf;
`else
    assign w_acc_nxt  = w_acc_base + w_ext;        // wraps modulo 2^ACC_W
    assign w_sat_nxt  = w_sat_base | s_overflow;
`endif

    assign w_close = s_tlast || (w_cnt_base == CW'(N_ACC - 1));

    // Only a closing beat needs the output register. It is stalled only while
    // that register holds a result the sink has not taken yet.
    assign s_tready = rst && !(w_close && r_m_tvalid && !m_tready);
    assign w_accept = s_tvalid && s_tready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && !w_close) w_state_nxt = S_ACCUM;
            S_ACCUM: if (w_accept &&  w_close) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_match <= '0;
            r_sat   <= 1'b0;
        end else if (w_accept) begin
            if (w_close) begin
                r_acc   <= '0;
                r_cnt   <= '0;
                r_match <= '0;
                r_sat   <= 1'b0;
            end else begin
                r_acc   <= w_acc_nxt;
                r_cnt   <= w_cnt_nxt;
                r_match <= w_match_nxt;
                r_sat   <= w_sat_nxt;
            end
        end
    end

    // A newly closed frame has priority over clearing the register. An accept
    // and a new load in the same cycle therefore replace the old result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_match  <= '0;
            r_m_count  <= '0;
            r_m_sat    <= 1'b0;
        end else if (w_accept && w_close) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= w_acc_nxt;
            r_m_match  <= w_match_nxt;
            r_m_count  <= w_cnt_nxt;
            r_m_sat    <= w_sat_nxt;
        end else if (m_tready) begin
            r_m_tvalid <= 1'b0;
        end
    end

    assign m_tvalid = r_m_tvalid;
    assign m_tdata  = r_m_tdata;
    assign m_match  = r_m_match;
    assign m_count  = r_m_count;
    assign m_sat    = r_m_sat;

endmodule
`default_nettype wire

// File: tb/tb_dsp_acc_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dsp_acc_stream
//  Purpose  : Self-checking bench for dsp_acc_stream (DW=8, N_ACC=4,
//             ACC_W=17). It expects saturating sums when DSP_ACC_SAT_EN is
//             defined and wrapping sums otherwise.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dsp_acc_stream;

    localparam int DW    = 8;
    localparam int N_ACC = 4;
    localparam int ACC_W = 17;
    localparam int CW    = $clog2(N_ACC + 1);
    localparam int PW    = 2 * DW + 1;

    typedef struct packed {
        logic [ACC_W-1:0] data;
        logic [CW-1:0]    match;
        logic [CW-1:0]    count;
        logic             sat;
    } res_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    s_tvalid = 1'b1;
    logic                    s_tready;
    logic signed [PW-1:0]    s_tdata = '0;
    logic                    s_overflow = 1'b0;
    logic                    s_sel = 1'b0;
    logic                    s_tlast = 1'b0;
    logic                    m_tvalid;
    logic                    m_tready = 1'b1;
    logic signed [ACC_W-1:0] m_tdata;
    logic [CW-1:0]           m_match;
    logic [CW-1:0]           m_count;
    logic                    m_sat;

    int total = 0;
    int bad   = 0;
    int tmo   = 0;

    res_t got_q[$];
    res_t exp_q[$];

    // behavioural model state: plain integer arithmetic per frame
    longint md_acc   = 0;
    int     md_cnt   = 0;
    int     md_match = 0;
    bit     md_sat   = 1'b0;

    dsp_acc_stream #(.DW(DW), .N_ACC(N_ACC), .ACC_W(ACC_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .s_tdata    (s_tdata),
        .s_overflow (s_overflow),
        .s_sel      (s_sel),
        .s_tlast    (s_tlast),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tdata    (m_tdata),
        .m_match    (m_match),
        .m_count    (m_count),
        .m_sat      (m_sat)
    );

    always #5 clk = ~clk;

    // record every result handshake; inputs change only just after posedge
    always @(negedge clk) begin
        if (rst && m_tvalid && m_tready)
            got_q.push_back('{data: m_tdata, match: m_match, count: m_count, sat: m_sat});
    end

    task automatic model_beat(input int x, input bit sel, input bit ovf, input bit last);
        longint lim_hi = (64'sd1 <<< (ACC_W - 1)) - 1;
        longint lim_lo = -(64'sd1 <<< (ACC_W - 1));
        md_acc = md_acc + x;
`ifdef DSP_ACC_SAT_EN
        if (md_acc > lim_hi) begin md_acc = lim_hi; md_sat = 1'b1; end
        else if (md_acc < lim_lo) begin md_acc = lim_lo; md_sat = 1'b1; end
`else
        md_acc = md_acc & ((64'sd1 <<< ACC_W) - 1);
        if (md_acc > lim_hi) md_acc = md_acc - (64'sd1 <<< ACC_W);
`endif
        md_sat   = md_sat | ovf;
        md_cnt   = md_cnt + 1;
        md_match = md_match + int'(sel);
        if (last || md_cnt == N_ACC) begin
            exp_q.push_back('{data: ACC_W'(md_acc), match: CW'(md_match),
                              count: CW'(md_cnt), sat: md_sat});
            md_acc = 0; md_cnt = 0; md_match = 0; md_sat = 1'b0;
        end
    endtask

    // Presents one beat and returns just after the edge that accepts it.
    task automatic send_beat(input int x, input bit sel, input bit ovf, input bit last);
        int n = 0;
        s_tdata = PW'(x); s_sel = sel; s_overflow = ovf; s_tlast = last; s_tvalid = 1'b1;
        @(negedge clk);
        while (!s_tready && n < 64) begin @(negedge clk); n++; end
        if (!s_tready) tmo++;
        @(posedge clk); #1;
        s_tvalid = 1'b0; s_tlast = 1'b0; s_sel = 1'b0; s_overflow = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++;
        if (m_tvalid !== 1'b0 || m_tdata !== '0 || m_match !== '0 || m_count !== '0 || m_sat !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b d=%0d m=%0d c=%0d s=%b, need all 0",
                     m_tvalid, m_tdata, m_match, m_count, m_sat);
        end
        total++;
        if (s_tready !== 1'b0) begin
            bad++; $display("FAIL reset_tready: got %b need 0", s_tready);
        end
        @(posedge clk); #1;
        rst = 1'b1; s_tvalid = 1'b0;
        @(negedge clk);
        total++;
        if (s_tready !== 1'b1) begin
            bad++; $display("FAIL post_reset_tready: got %b need 1", s_tready);
        end
    endtask

    task automatic test_basic;
        @(posedge clk); #1;
        m_tready = 1'b1;
        send_beat(100, 1, 0, 0);
        send_beat(200, 0, 0, 0);
        send_beat(-50, 1, 0, 0);
        @(negedge clk);
        total++;
        if (m_tvalid !== 1'b0) begin
            bad++; $display("FAIL basic_early_valid: got %b need 0", m_tvalid);
        end
        @(posedge clk); #1;
        send_beat(7, 1, 0, 0);
        @(negedge clk);
        total++;
        if (m_tvalid !== 1'b1 || m_tdata !== ACC_W'(257) || m_match !== CW'(3) ||
            m_count !== CW'(4) || m_sat !== 1'b0) begin
            bad++;
            $display("FAIL basic_frame: got v=%b d=%0d m=%0d c=%0d s=%b, need v=1 d=257 m=3 c=4 s=0",
                     m_tvalid, m_tdata, m_match, m_count, m_sat);
        end
        @(negedge clk);
        total++;
        if (m_tvalid !== 1'b0) begin
            bad++; $display("FAIL basic_valid_one_cycle: got %b need 0", m_tvalid);
        end
    endtask

    task automatic test_early_close;
        @(posedge clk); #1;
        send_beat(10, 0, 0, 0);
        send_beat(20, 0, 0, 1);
        @(negedge clk);
        total++;
        if (m_tvalid !== 1'b1 || m_tdata !== ACC_W'(30) || m_count !== CW'(2)) begin
            bad++;
            $display("FAIL early_close: got v=%b d=%0d c=%0d, need v=1 d=30 c=2", m_tvalid, m_tdata, m_count);
        end
        @(posedge clk); #1;
        send_beat(1, 0, 0, 0);
        send_beat(2, 0, 0, 0);
        send_beat(3, 0, 0, 0);
        send_beat(4, 0, 0, 0);
        @(negedge clk);
        total++;
        if (m_tvalid !== 1'b1 || m_tdata !== ACC_W'(10) || m_count !== CW'(4) || m_match !== CW'(0)) begin
            bad++;
            $display("FAIL fresh_frame: got v=%b d=%0d c=%0d m=%0d, need v=1 d=10 c=4 m=0",
                     m_tvalid, m_tdata, m_count, m_match);
        end
    endtask

    task automatic test_backpressure;
        int tmo0;
        @(posedge clk); #1;
        m_tready = 1'b0;
        got_q.delete();
        tmo0 = tmo;
        send_beat(1, 1, 0, 0);
        send_beat(2, 0, 0, 1);
        send_beat(5, 0, 0, 0);                   // non-closing: must not stall
        total++;
        if (tmo != tmo0) begin
            bad++; $display("FAIL bp_nonclosing_stalled: timeouts got %0d need %0d", tmo, tmo0);
        end
        s_tdata = PW'(6); s_tlast = 1'b1; s_sel = 1'b1; s_tvalid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (s_tready !== 1'b0 || m_tvalid !== 1'b1 || m_tdata !== ACC_W'(3) || m_count !== CW'(2)) begin
                bad++;
                $display("FAIL bp_hold: got rdy=%b v=%b d=%0d c=%0d, need rdy=0 v=1 d=3 c=2",
                         s_tready, m_tvalid, m_tdata, m_count);
            end
        end
        @(posedge clk); #1;
        m_tready = 1'b1;
        @(negedge clk);
        total++;
        if (s_tready !== 1'b1) begin
            bad++; $display("FAIL bp_release_tready: got %b need 1", s_tready);
        end
        @(posedge clk); #1;
        s_tvalid = 1'b0; s_tlast = 1'b0; s_sel = 1'b0;
        @(negedge clk);
        total++;
        if (m_tvalid !== 1'b1 || m_tdata !== ACC_W'(11) || m_count !== CW'(2) || m_match !== CW'(1)) begin
            bad++;
            $display("FAIL bp_second_result: got v=%b d=%0d c=%0d m=%0d, need v=1 d=11 c=2 m=1",
                     m_tvalid, m_tdata, m_count, m_match);
        end
        repeat (2) @(negedge clk);
        total++;
        if (got_q.size() != 2 || got_q[0].data !== ACC_W'(3) || got_q[1].data !== ACC_W'(11)) begin
            bad++;
            $display("FAIL bp_delivered: got %0d results, need 2 (3 then 11)", got_q.size());
        end
    endtask

    task automatic test_saturation;
        @(posedge clk); #1;
        send_beat(65535, 0, 0, 0);
        send_beat(65535, 0, 0, 1);
        @(negedge clk);
        total++;
`ifdef DSP_ACC_SAT_EN
        if (m_tvalid !== 1'b1 || m_tdata !== ACC_W'(65535) || m_sat !== 1'b1) begin
            bad++;
            $display("FAIL saturation: got v=%b d=%0d s=%b, need v=1 d=65535 s=1", m_tvalid, m_tdata, m_sat);
        end
`else
        if (m_tvalid !== 1'b1 || m_tdata !== ACC_W'(-2) || m_sat !== 1'b0) begin
            bad++;
            $display("FAIL wrap: got v=%b d=%0d s=%b, need v=1 d=-2 s=0", m_tvalid, m_tdata, m_sat);
        end
`endif
    endtask

    task automatic test_overflow;
        @(posedge clk); #1;
        send_beat(3, 0, 0, 0);
        send_beat(3, 0, 1, 0);
        send_beat(3, 0, 0, 0);
        send_beat(3, 0, 0, 0);
        @(negedge clk);
        total++;
        if (m_tvalid !== 1'b1 || m_sat !== 1'b1 || m_tdata !== ACC_W'(12)) begin
            bad++; $display("FAIL overflow_flag: got v=%b s=%b d=%0d, need v=1 s=1 d=12", m_tvalid, m_sat, m_tdata);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) send_beat(-1, 0, 0, 0);
        @(negedge clk);
        total++;
        if (m_tvalid !== 1'b1 || m_sat !== 1'b0 || m_tdata !== ACC_W'(-4)) begin
            bad++; $display("FAIL overflow_cleared: got v=%b s=%b d=%0d, need v=1 s=0 d=-4", m_tvalid, m_sat, m_tdata);
        end
    endtask

    task automatic test_reset_midframe;
        @(posedge clk); #1;
        m_tready = 1'b0;
        send_beat(1, 0, 0, 0);
        send_beat(1, 0, 0, 1);                   // pending result
        send_beat(3, 0, 0, 0);
        send_beat(4, 0, 0, 0);                   // partial frame of 2 beats
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (m_tvalid !== 1'b0 || m_tdata !== '0 || m_match !== '0 || m_count !== '0 ||
            m_sat !== 1'b0 || s_tready !== 1'b0) begin
            bad++;
            $display("FAIL midframe_reset: got v=%b d=%0d m=%0d c=%0d s=%b rdy=%b, need all 0",
                     m_tvalid, m_tdata, m_match, m_count, m_sat, s_tready);
        end
        @(posedge clk); #1;
        rst = 1'b1; m_tready = 1'b1;
        got_q.delete();
        send_beat(5, 1, 0, 0);
        send_beat(5, 0, 0, 0);
        send_beat(5, 0, 0, 0);
        send_beat(5, 0, 0, 0);
        @(negedge clk);
        total++;
        if (m_tvalid !== 1'b1 || m_tdata !== ACC_W'(20) || m_count !== CW'(4) || m_match !== CW'(1)) begin
            bad++;
            $display("FAIL after_reset_frame: got v=%b d=%0d c=%0d m=%0d, need v=1 d=20 c=4 m=1",
                     m_tvalid, m_tdata, m_count, m_match);
        end
        @(negedge clk);
        total++;
        if (got_q.size() != 1) begin
            bad++; $display("FAIL after_reset_count: got %0d results need 1", got_q.size());
        end
    endtask

    task automatic test_random;
        bit done = 1'b0;
        int tmo0 = tmo;
        @(posedge clk); #1;
        got_q.delete(); exp_q.delete();
        md_acc = 0; md_cnt = 0; md_match = 0; md_sat = 1'b0;
        fork
            begin
                for (int b = 0; b < 300; b++) begin
                    int  x;
                    bit  sel, ovf, last;
                    if ($urandom_range(0, 1) == 1) begin
                        x = int'($urandom_range(0, 131071));
                        if (x >= 65536) x = x - 131072;
                    end else begin
                        x = int'($urandom_range(0, 2000)) - 1000;
                    end
                    sel  = 1'($urandom_range(0, 1));
                    ovf  = ($urandom_range(0, 15) == 0);
                    last = (b == 299) || ($urandom_range(0, 4) == 0);
                    model_beat(x, sel, ovf, last);
                    send_beat(x, sel, ovf, last);
                    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    m_tready = 1'($urandom_range(0, 1));
                end
                m_tready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        @(negedge clk);
        total++;
        if (tmo != tmo0) begin
            bad++; $display("FAIL random_timeout: timeouts got %0d need %0d", tmo, tmo0);
        end
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++; $display("FAIL random_result_count: got %0d need %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL random_result[%0d]: got d=%0d m=%0d c=%0d s=%b, need d=%0d m=%0d c=%0d s=%b",
                         i, $signed(got_q[i].data), got_q[i].match, got_q[i].count, got_q[i].sat,
                         $signed(exp_q[i].data), exp_q[i].match, exp_q[i].count, exp_q[i].sat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_early_close();
        test_backpressure();
        test_saturation();
        test_overflow();
        test_reset_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/dsp_acc_stream.md
# dsp_acc_stream

Downstream consumer of the pre-add/multiply/compare DSP stage. Takes its registered product, overflow bit and match flag as a valid/ready stream and accumulates up to `N_ACC` products per frame into a wider signed sum. Emits one result beat per frame with match count, beat count and a sticky saturation/overflow flag. Sits between the DSP stage and the frame-level result sink.

## Interface

- `DW`, 8: operand width of the upstream DSP stage. Product width is `2*DW+1`.
- `N_ACC`, 16: maximum beats per frame, ≥2.
- `ACC_W`, 24: accumulator/result width, ≥ `2*DW+1`.
- `CW`: localparam = `$clog2(N_ACC+1)`.

Ports:

- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `s_tvalid`  in  1  upstream product valid.
- `s_tready`  out  1  beat accepted when `s_tvalid && s_tready`.
- `s_tdata`  in  `2*DW+1`  signed product from the DSP stage.
- `s_overflow`  in  1  upstream overflow bit for this beat.
- `s_sel`  in  1  upstream compare-match flag for this beat.
- `s_tlast`  in  1  closes the frame early on this beat.
- `m_tvalid`  out  1  result valid.
- `m_tready`  in  1  downstream accept.
- `m_tdata`  out  `ACC_W`  signed frame sum.
- `m_match`  out  `CW`  count of beats with `s_sel=1`.
- `m_count`  out  `CW`  beats in frame (1..`N_ACC`).
- `m_sat`  out  1  frame saturated or saw `s_overflow`.

## Operation

- FSM has two states.
  - IDLE: `acc=0`, `cnt=0`, `match=0`, `sat=0`.
  - ACCUM: frame open.
- Transitions:
  - IDLE→ACCUM: accepted beat that is not frame-closing.
  - ACCUM→IDLE: accepted closing beat.
  - A closing beat in IDLE stays in IDLE. This covers a 1-beat frame via `s_tlast`.
- Closing beat: `s_tlast=1` or `cnt==N_ACC-1`.
- Per accepted beat:
  - `s_tdata` is sign-extended to `ACC_W` and added to `acc`.
  - `cnt+=1`.
  - `match+=s_sel`.
  - `sat|=s_overflow`.
- On a closing beat:
  - Final sum, counts and flag (including this beat) load the output register.
  - `m_tvalid` is set.
  - Accumulator state returns to IDLE values in the same edge.
- Output register holds one result. It is stable while `m_tvalid && !m_tready`. It clears `m_tvalid` on `m_tvalid && m_tready` unless a new result loads in the same edge; a new result takes priority.
- `s_tready`:
  - 0 while `rst` is low.
  - Otherwise 0 only when the presented beat would be closing and `m_tvalid && !m_tready`.
  - Non-closing beats are never stalled.
- `s_tready` is combinational from `m_tvalid`, `m_tready`, `cnt` and `s_tlast`. There is no path from `s_tvalid`.
- Accumulation arithmetic is signed and `ACC_W` wide. Overflow handling is selected under Configuration.

## Timing

- Reset (async assert, sync deassert expected): `m_tvalid=0`, `m_tdata=0`, `m_match=0`, `m_count=0`, `m_sat=0`, FSM=IDLE, `s_tready=0`.
- Throughput: one beat per cycle with no backpressure.
- Latency: `m_tvalid` rises on the edge that accepts the closing beat, i.e. visible the cycle after the handshake.
- Back-to-back frames: a result can be emitted every cycle if `m_tready=1`, e.g. consecutive `s_tlast` beats.
- Simultaneous output accept and new closing beat in one cycle: both succeed, and the new result replaces the old.
- Reset mid-frame discards the partial frame and any pending result.

## Configuration

- `DSP_ACC_SAT_EN` defined:
  - Accumulator add saturates to `+(2^(ACC_W-1)-1)` / `-2^(ACC_W-1)`.
  - Any clamp sets the frame's sticky `sat`.
  - Saturation is sticky within the frame; later adds start from the clamped value.
- Not defined:
  - Add wraps modulo `2^ACC_W`.
  - `m_sat` reflects only `s_overflow`.

## Test plan

- **Basic frame.** `N_ACC=4`, beats `100,200,-50,7`, `s_sel=1,0,1,1`, `m_tready=1`. Expect:
  - `m_tdata=257`, `m_match=3`, `m_count=4`, `m_sat=0`.
  - `m_tvalid` high exactly one cycle, the cycle after beat 4.
- **Early close.** Beats `10`, `20` with `s_tlast` on the second. Expect `m_tdata=30`, `m_count=2`. The next beat starts a fresh frame from 0.
- **Backpressure.** Hold `m_tready=0` with a result pending, then drive a second frame. Expect:
  - Non-closing beats are accepted.
  - `s_tready=0` on the closing beat until `m_tready=1`.
  - First result unchanged until accepted; no beat lost.
- **Saturation.** `DW=8`, `ACC_W=17`, beats `65535`, `65535`, `s_tlast`.
  - With `DSP_ACC_SAT_EN`: `m_tdata=65535`, `m_sat=1`.
  - Without: `m_tdata=-2`, `m_sat=0`.
- **Upstream overflow.** One beat with `s_overflow=1` in a 4-beat frame. Expect `m_sat=1`; the next frame returns `m_sat=0`.
- **Reset mid-frame.** Reset low for 1 cycle after 2 beats with a result pending. Expect all outputs 0. Next frame `5,5,5,5` gives `m_tdata=20`, `m_count=4`.
